// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external RAM port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states; encodings are fixed so debug tooling can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Byte-lane enable codes.
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Single-lane enable for a byte store at the given byte offset.
  function automatic logic [3:0] byte_be(input logic [1:0] offs);
    return BE_BYTE0 << offs;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_lane.sv
// Byte-lane encoder: turns the byte flag and byte offset into lane enables
// and replicates store data so the selected lane carries the byte.
module byte_lane_enc
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic        i_byte,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  // Word accesses use all lanes and pass data through; byte stores hit one lane.
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    if (i_byte) begin
      o_be    = byte_be(i_addr_lo);
      o_wdata = {4{i_wdata[7:0]}};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external word-wide RAM port between instruction fetch
// (read only) and the MEM stage (loads, word/byte stores). MEM has fixed
// priority. Each access is a multi-cycle SRAM cycle with a programmable wait.
//
// Handshake: a requester raises req with stable fields and holds it until its
// ack pulse; the ack is high for exactly one cycle, during which rdata is
// valid. Dropping req at the edge ending the ack cycle ends the transaction;
// keeping it high chains another access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic              mem_byte,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_grant;
  logic [3:0]          r_cnt;
  owner_t              r_owner;
  logic                r_if_ack;
  logic                r_mem_ack;
  logic [31:0]         r_rdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_wdata;
  logic [3:0]          r_ram_be;
  logic                r_ram_we;
  logic                r_ram_oe;
  logic                r_busy;

  // Request selected in IDLE: MEM wins whenever it is asking.
  logic [31:0]         w_sel_addr;
  logic                w_sel_write;
  logic                w_sel_byte;
  logic [3:0]          w_enc_be;
  logic [31:0]         w_enc_wdata;
  logic                w_unused_addr_bits;

  assign w_sel_addr  = mem_req ? mem_addr : if_addr;
  assign w_sel_write = mem_req & mem_write;
  assign w_sel_byte  = mem_req & mem_write & mem_byte;
  assign w_unused_addr_bits = ^w_sel_addr[31:ADDR_W+2];

  byte_lane_enc u_lane (
    .i_addr_lo (w_sel_addr[1:0]),
    .i_byte    (w_sel_byte),
    .i_wdata   (mem_wdata),
    .o_be      (w_enc_be),
    .o_wdata   (w_enc_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req || if_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: if (r_cnt == 4'd0) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered datapath: latch on grant, hold RAM controls through BUSY,
  // capture read data and pulse the owner's ack on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_owner     <= OWN_IF;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_rdata     <= 32'd0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
      r_ram_be    <= BE_NONE;
      r_ram_we    <= 1'b0;
      r_ram_oe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_busy    <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner     <= mem_req ? OWN_MEM : OWN_IF;
            r_cnt       <= WAIT_INIT;
            r_ram_addr  <= w_sel_addr[ADDR_W+1:2];
            r_ram_wdata <= w_enc_wdata;
            r_ram_be    <= w_enc_be;
            r_ram_we    <= w_sel_write;
            r_ram_oe    <= ~w_sel_write;
          end
        end
        ST_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata  <= ram_rdata;
            r_ram_we <= 1'b0;
            r_ram_oe <= 1'b0;
            r_ram_be <= BE_NONE;
            if (r_owner == OWN_MEM) r_mem_ack <= 1'b1;
            else                    r_if_ack  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign mem_ack   = r_mem_ack;
  assign if_rdata  = r_rdata;
  assign mem_rdata = r_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_be    = r_ram_be;
  assign ram_we    = r_ram_we;
  assign ram_oe    = r_ram_oe;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external word-wide RAM port between instruction fetch (read-only) and the MEM stage (word/byte load and store).
- Fixed priority: MEM stage first, because it holds the older instruction and the pipeline stalls behind it.
- Each access is a multi-cycle SRAM cycle sequenced by a small FSM with a programmable wait count.
- Results return to the owner on a one-cycle ack pulse.

Parameters:
- ADDR_W, 20: word-address width of the external RAM.
- WAIT_CYCLES, 1: extra cycles the address and control are held before read data is sampled (range 0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  32  fetched word
- mem_req  in  1  MEM-stage request; held with fields until mem_ack
- mem_write  in  1  1 = store, 0 = load
- mem_byte  in  1  1 = byte store, 0 = word (ignored for loads)
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; byte store uses [7:0]
- mem_ack  out  1  one-cycle pulse; mem_rdata valid this cycle for loads
- mem_rdata  out  32  loaded word; MEM stage does byte extraction
- ram_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data from RAM
- ram_be  out  4  byte-lane enables
- ram_we  out  1  write strobe
- ram_oe  out  1  output enable
- busy  out  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered. On rst at a clk edge, every output goes to 0, state goes to IDLE and counter to 0. An in-flight access is abandoned and produces no ack.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_req is high, grant MEM. Otherwise, if if_req is high, grant IF. Otherwise stay in IDLE.
  - On grant: latch owner, addr, write, byte and wdata; cnt <= WAIT_CYCLES; go to BUSY.
  - On grant, drive ram_addr, ram_wdata, ram_be and ram_we/ram_oe from the latched request at the same edge.
- BUSY:
  - RAM outputs are held stable for every BUSY cycle.
  - Reads: ram_oe=1, ram_we=0, ram_be=4'b1111.
  - Writes: ram_we=1, ram_oe=0.
    - Word store: ram_be=4'b1111, ram_wdata=wdata.
    - Byte store: ram_be=4'b0001<<addr[1:0], ram_wdata={4{wdata[7:0]}}.
  - If cnt!=0, decrement cnt.
  - If cnt==0: capture ram_rdata into the shared rdata register (writes capture as well, value don't-care), clear ram_we/ram_oe/ram_be, and go to DONE.
  - BUSY lasts WAIT_CYCLES+1 cycles.
- DONE:
  - The owner's ack is high for exactly this cycle. The other ack stays 0.
  - if_rdata and mem_rdata both present the rdata register.
  - Requests are ignored in DONE. Next state is IDLE.
- Latency: a request first seen in IDLE at cycle T gives ack in cycle T+WAIT_CYCLES+2. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Requester rules:
  - The requester deasserts req at the edge ending its ack cycle, or keeps it high to chain another access.
  - Fields must stay stable from req rise until ack. The arbiter latches them at grant, so later changes are tolerated.
- Requests that arrive while BUSY/DONE wait. The losing requester is never dropped. IF may starve only while MEM requests continuously, which is intended.
- Misaligned word addresses: addr[1:0] is ignored (word-aligned access); no exception is raised.
- If if_req and mem_req rise in the same IDLE cycle, MEM is granted and IF is served in the following IDLE.

Decomposition:
- Shared header mem_opt.vh: add MEMWRITE_OPT-style codes reused for ram_be generation.
- Local header mem_port_arbiter.vh: state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and owner encodings (OWN_IF=0, OWN_MEM=1).
- One natural sub-module, byte_lane_enc: combinational, takes addr[1:0] and the byte flag, produces ram_be and the replicated write data.
- FSM and counter stay in the top module.

Test Plan:
- IF read: WAIT_CYCLES=1, if_req at cycle 0, if_addr=0x00000010, ram_rdata=0xDEADBEEF. Expect ram_addr=4 and ram_oe=1 in cycles 1-2, if_ack high in cycle 3 only, if_rdata=0xDEADBEEF.
- Contention: if_req and mem_req (load, addr 0x20) both rise at cycle 0. Expect mem_ack at cycle 3, then IF granted at cycle 4 and if_ack at cycle 7; if_ack never coincides with mem_ack.
- Byte store: mem_write=1, mem_byte=1, mem_addr=0x103, mem_wdata=0x000000A5. Expect ram_be=4'b1000, ram_wdata=0xA5A5A5A5, ram_addr=0x40, ram_we high for exactly 2 cycles.
- Word store: mem_addr=0x106 (misaligned), mem_wdata=0x12345678. Expect ram_addr=0x41, ram_be=4'b1111, ram_wdata=0x12345678.
- Reset mid-access: assert rst during the first BUSY cycle of an IF read. Expect ram_oe/ram_we/busy=0 the next cycle and no if_ack. A re-asserted if_req after reset completes normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: measure request-to-ack latency of 2 and 5 cycles respectively. With chained mem_req held high, expect mem_ack every 3 and 6 cycles.
